// File: rtl/reg_bank_32x32_pkg.sv
// Shared constants and FSM encoding for the 32x32 register bank.
// Widths are fixed by the downstream 32:1 read mux.
package reg_bank_32x32_pkg;

    localparam int RB_WIDTH  = 32;
    localparam int RB_DEPTH  = 32;
    localparam int RB_AW     = 5;
    localparam int RB_BANK_W = RB_WIDTH * RB_DEPTH;

    localparam logic [RB_AW-1:0] RB_LAST_IDX = RB_AW'(RB_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } rb_state_t;

endpackage

// File: rtl/reg_bank_32x32_if.sv
// Write port, clear control and flattened bank output of the register bank.
// master = write/clear source, slave = the bank itself.
interface reg_bank_32x32_if;
    import reg_bank_32x32_pkg::*;

    logic                  wr_en;
    logic [RB_AW-1:0]      wr_addr;
    logic [RB_WIDTH-1:0]   wr_data;
    logic                  wr_rdy;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic [RB_BANK_W-1:0]  bank;

    modport master (
        output wr_en, wr_addr, wr_data, clr_req,
        input  wr_rdy, clr_busy, clr_done, bank
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_req,
        output wr_rdy, clr_busy, clr_done, bank
    );

endinterface

// File: rtl/reg_bank_32x32_word.sv
// One register word: async active-low reset, write enable, synchronous clear.
// Latency 1 cycle; clear wins over a simultaneous write.
module reg_bank_32x32_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (wr_en) begin
            q <= wr_data;
        end
    end

endmodule

// File: rtl/reg_bank_32x32.sv
// 32x32 register bank with one write port and a one-word-per-cycle clear engine.
// Latency: write visible on bank 1 cycle after the accepting edge; clear takes 32+1 cycles.
// Backpressure: wr_rdy low outside IDLE drops writes; REGBANK_R0_ZERO_EN hardwires word 0.
module reg_bank_32x32
    import reg_bank_32x32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    reg_bank_32x32_if.slave  rb
);

    rb_state_t                          state;
    logic [RB_AW-1:0]                   clr_cnt;
    logic                               clr_busy_q;
    logic                               clr_done_q;
    logic                               wr_rdy;
    logic                               wr_fire;
    logic                               clr_active;
    logic [RB_DEPTH-1:0][RB_WIDTH-1:0]  words;

    assign wr_rdy     = (state == ST_IDLE);
    assign wr_fire    = rb.wr_en && wr_rdy;
    assign clr_active = (state == ST_CLEAR);

    assign rb.wr_rdy   = wr_rdy;
    assign rb.clr_busy = clr_busy_q;
    assign rb.clr_done = clr_done_q;
    assign rb.bank     = words;

    // Busy/done are registered alongside the state so they carry no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rb.clr_req) begin
                        state      <= ST_CLEAR;
                        clr_cnt    <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == RB_LAST_IDX) begin
                        state      <= ST_DONE;
                        clr_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGBANK_R0_ZERO_EN
    localparam int FIRST_WORD = 1;
    assign words[0] = '0;
`else
    localparam int FIRST_WORD = 0;
`endif

    // Per-word decode of the write address and the clear counter.
    for (genvar i = FIRST_WORD; i < RB_DEPTH; i++) begin : g_word
        logic wr_sel;
        logic clr_sel;

        assign wr_sel  = wr_fire && (rb.wr_addr == RB_AW'(i));
        assign clr_sel = clr_active && (clr_cnt == RB_AW'(i));

        reg_bank_32x32_word #(
            .WIDTH (RB_WIDTH)
        ) u_word (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_sel),
            .clr     (clr_sel),
            .wr_data (rb.wr_data),
            .q       (words[i])
        );
    end

endmodule
